hazard_ctrl: RTL and testbench

- Parametrised successor to the pipeline load-use hazard unit of the MIPS core.
- Keeps an internal scoreboard of in-flight loads with a configurable load-to-use latency.
- Produces the bubble, PC and IF/ID write-enable, and IF/ID flush controls.
- Freezes the whole pipeline while data memory is not ready. Sits beside the ID stage and drives the PC, IF/ID and ID/EX control muxes.

---
 rtl/hazard_ctrl_if.sv | 31 +++
 rtl/hazard_ctrl.sv | 53 +++++
 tb/tb_hazard_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-stage hazard inputs and pipeline control outputs of hazard_ctrl
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs_i;
  logic [REG_W-1:0] id_rt_i;
  logic id_use_rs_i;
  logic id_use_rt_i;
  logic id_is_load_i;
  logic [REG_W-1:0] id_load_rd_i;
  logic branch_taken_i;
  logic mem_ready_i;
  logic mem_req_i;
  logic pc_write_o;
  logic if_id_write_o;
  logic bubble_o;
  logic flush_o;
  logic freeze_o;
  logic [CNT_W-1:0] stall_cnt_o;
  modport master (
    output id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, id_is_load_i, id_load_rd_i,
    output branch_taken_i, mem_ready_i, mem_req_i,
    input pc_write_o, if_id_write_o, bubble_o, flush_o, freeze_o, stall_cnt_o
  );
  modport slave (
    input id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, id_is_load_i, id_load_rd_i,
    input branch_taken_i, mem_ready_i, mem_req_i,
    output pc_write_o, if_id_write_o, bubble_o, flush_o, freeze_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use scoreboard hazard unit driving stall/bubble/flush/freeze controls.
// Optional HAZARD_STATS_EN adds a saturating stall/freeze cycle counter on stall_cnt_o.
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W = 16
) (
  input logic clk_i,
  input logic rst_i,
  hazard_ctrl_if.slave hz
);
  logic [LOAD_LAT-1:0] sb_v;
  logic [LOAD_LAT-1:0] hits;
  logic [LOAD_LAT-1:0][REG_W-1:0] sb_rd;
  logic freeze;
  logic hit;
  for (genvar g = 0; g < LOAD_LAT; g++) begin : g_hit
    assign hits[g] = sb_v[g] && (sb_rd[g] != '0) &&
                     ((hz.id_use_rs_i && sb_rd[g] == hz.id_rs_i) ||
                      (hz.id_use_rt_i && sb_rd[g] == hz.id_rt_i));
  end
  assign freeze = hz.mem_req_i && !hz.mem_ready_i;
  assign hit = |hits;
  assign hz.freeze_o = freeze;
  assign hz.bubble_o = !freeze && hit;
  assign hz.flush_o = !freeze && !hit && hz.branch_taken_i;
  assign hz.pc_write_o = !freeze && !hit;
  assign hz.if_id_write_o = !freeze && !hit;
  // a stalled ID instruction must not enter EX, so entry 0 becomes empty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_v <= '0;
      sb_rd <= '0;
    end else if (!freeze) begin
      for (int k = LOAD_LAT - 1; k > 0; k--) begin
        sb_v[k] <= sb_v[k-1];
        sb_rd[k] <= sb_rd[k-1];
      end
      sb_v[0] <= !hit && hz.id_is_load_i;
      sb_rd[0] <= hz.id_load_rd_i;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt <= '0;
    else if ((freeze || hit) && !(&cnt)) cnt <= cnt + 1'b1;
  end
  assign hz.stall_cnt_o = cnt;
`else
  assign hz.stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench running LOAD_LAT=1 and LOAD_LAT=3 instances on shared stimulus
module tb_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam logic [4:0] NRM = 5'b11000;
  localparam logic [4:0] BUB = 5'b00100;
  localparam logic [4:0] FLS = 5'b11010;
  localparam logic [4:0] FRZ = 5'b00001;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  logic [9:0] exp_q[$];
  logic [CNT_W-1:0] cnt1 = '0;
  logic [CNT_W-1:0] cnt3 = '0;
  hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) i1 ();
  hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) i3 ();
  hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(1), .CNT_W(CNT_W)) u1 (.clk_i(clk), .rst_i(rst), .hz(i1));
  hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(3), .CNT_W(CNT_W)) u3 (.clk_i(clk), .rst_i(rst), .hz(i3));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                     input logic ld, input logic [4:0] ldrd, input logic br, input logic mreq,
                     input logic mrdy);
    i1.id_rs_i = rs; i1.id_rt_i = rt; i1.id_use_rs_i = urs; i1.id_use_rt_i = urt;
    i1.id_is_load_i = ld; i1.id_load_rd_i = ldrd; i1.branch_taken_i = br;
    i1.mem_req_i = mreq; i1.mem_ready_i = mrdy;
    i3.id_rs_i = rs; i3.id_rt_i = rt; i3.id_use_rs_i = urs; i3.id_use_rt_i = urt;
    i3.id_is_load_i = ld; i3.id_load_rd_i = ldrd; i3.branch_taken_i = br;
    i3.mem_req_i = mreq; i3.mem_ready_i = mrdy;
  endtask
  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                     input logic ld, input logic [4:0] ldrd, input logic br, input logic mreq,
                     input logic mrdy, input logic [4:0] e1, input logic [4:0] e3);
    @(posedge clk);
    #1;
    drv(rs, rt, urs, urt, ld, ldrd, br, mreq, mrdy);
    exp_q.push_back({e1, e3});
  endtask
  task automatic nop(input int n);
    repeat (n) cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NRM, NRM);
  endtask
  task automatic async_rst(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_ctl1"}, {i1.pc_write_o, i1.if_id_write_o, i1.bubble_o, i1.flush_o, i1.freeze_o}, NRM);
    chk({tag, "_ctl3"}, {i3.pc_write_o, i3.if_id_write_o, i3.bubble_o, i3.flush_o, i3.freeze_o}, NRM);
    chk({tag, "_cnt1"}, i1.stall_cnt_o, 0);
    chk({tag, "_cnt3"}, i3.stall_cnt_o, 0);
    cnt1 = '0;
    cnt3 = '0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      chk("lat1_ctl", {i1.pc_write_o, i1.if_id_write_o, i1.bubble_o, i1.flush_o, i1.freeze_o}, e[9:5]);
      chk("lat3_ctl", {i3.pc_write_o, i3.if_id_write_o, i3.bubble_o, i3.flush_o, i3.freeze_o}, e[4:0]);
      chk("lat1_cnt", i1.stall_cnt_o, cnt1);
      chk("lat3_cnt", i3.stall_cnt_o, cnt3);
      if (STATS && (e[7] || e[5]) && !(&cnt1)) cnt1 = cnt1 + 1'b1;
      if (STATS && (e[2] || e[0]) && !(&cnt3)) cnt3 = cnt3 + 1'b1;
    end
  end
  initial begin
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #3;
    chk("rst_ctl1", {i1.pc_write_o, i1.if_id_write_o, i1.bubble_o, i1.flush_o, i1.freeze_o}, NRM);
    chk("rst_ctl3", {i3.pc_write_o, i3.if_id_write_o, i3.bubble_o, i3.flush_o, i3.freeze_o}, NRM);
    chk("rst_cnt1", i1.stall_cnt_o, 0);
    chk("rst_cnt3", i3.stall_cnt_o, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    nop(2);
    // back-to-back load $8 then rs user
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, NRM, NRM);
    cyc(5'd8, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, BUB, BUB);
    cyc(5'd8, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NRM, BUB);
    cyc(5'd8, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NRM, BUB);
    cyc(5'd8, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NRM, NRM);
    nop(3);
    // load $9, independent instruction, then rt user
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, NRM, NRM);
    cyc(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NRM, NRM);
    cyc(5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NRM, BUB);
    cyc(5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NRM, BUB);
    cyc(5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NRM, NRM);
    nop(3);
    // $0 never hazards; unread rs field never hazards
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, NRM, NRM);
    cyc(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NRM, NRM);
    nop(3);
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, NRM, NRM);
    cyc(5'd5, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NRM, NRM);
    cyc(5'd5, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NRM, NRM);
    nop(3);
    // memory freeze during a pending hazard holds the scoreboard
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, NRM, NRM);
    repeat (4) cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, FRZ);
    cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, BUB, BUB);
    cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NRM, BUB);
    cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NRM, BUB);
    cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NRM, NRM);
    nop(3);
    // stall beats flush; flush once the hazard clears
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, NRM, NRM);
    cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, BUB, BUB);
    cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, FLS, BUB);
    cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, FLS, BUB);
    cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, FLS, FLS);
    nop(3);
    // counter saturation over 20 freeze cycles, then reset mid-stall
    async_rst("rst_a");
    repeat (20) cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, FRZ);
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, NRM, NRM);
    cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, BUB, BUB);
    async_rst("rst_mid");
    cyc(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NRM, NRM);
    nop(2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
